// File: rtl/reflet_uart_tx_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM encodings and depth limits.
package reflet_uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  localparam int DEPTH_LOG2_MIN = 1;
  localparam int DEPTH_LOG2_MAX = 8;

endpackage

// File: rtl/reflet_fifo_mem.sv
// Byte storage for the transmit FIFO: synchronous write, asynchronous read.
module reflet_fifo_mem #(
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [depth_log2-1:0] write_addr,
  input  logic [7:0]            write_data,
  input  logic [depth_log2-1:0] read_addr,
  output logic [7:0]            read_data
);

  logic [7:0] mem [2**depth_log2];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/reflet_uart_tx_fifo.sv
// Transmit FIFO feeding the UART core one byte at a time.
// Optional sticky overflow flag: define REFLET_UART_TX_FIFO_OVERFLOW_EN.
module reflet_uart_tx_fifo
  import reflet_uart_tx_pkg::*;
#(
  parameter int depth_log2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic [depth_log2:0] count,
  output logic                busy,
`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
  output logic                overflow,
  input  logic                overflow_clr,
`endif
  output logic [7:0]          data_tx,
  output logic                start_transmit,
  input  logic                end_transmit
);

  if (depth_log2 < DEPTH_LOG2_MIN || depth_log2 > DEPTH_LOG2_MAX) begin : g_bad_depth
    $error("reflet_uart_tx_fifo: depth_log2 out of range");
  end

  localparam int PW = depth_log2 + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [7:0]    head;
  logic          do_push, do_pop;
  tx_state_t     state, state_next;

  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {depth_log2{1'b0}}};
  assign empty   = wr_ptr == rd_ptr;
  assign count   = wr_ptr - rd_ptr;
  assign busy    = state != TX_IDLE;
  assign do_pop  = (state == TX_IDLE) && !empty;
  assign do_push = push && !full && !flush;
  assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  reflet_fifo_mem #(.depth_log2(depth_log2)) u_mem (
    .clk        (clk),
    .write_en   (do_push),
    .write_addr (wr_ptr[depth_log2-1:0]),
    .write_data (push_data),
    .read_addr  (rd_ptr[depth_log2-1:0]),
    .read_data  (head)
  );

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (!empty) state_next = TX_START;
      TX_START: state_next = TX_WAIT;
      TX_WAIT:  if (end_transmit) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= TX_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      data_tx        <= 8'h00;
      start_transmit <= 1'b0;
    end else begin
      state          <= state_next;
      rd_ptr         <= rd_ptr_next;
      start_transmit <= do_pop;
      if (do_pop) data_tx <= head;
      // Flush empties against the post-pop read pointer so a same-cycle pop
      // leaves the FIFO empty rather than wrapping the count.
      if (flush)        wr_ptr <= rd_ptr_next;
      else if (do_push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!reset)                overflow <= 1'b0;
    else if (push && full)     overflow <= 1'b1;
    else if (overflow_clr)     overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_reflet_uart_tx_fifo.sv
// Directed self-checking bench for reflet_uart_tx_fifo at depth_log2 = 2.
module tb_reflet_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       flush = 1'b0;
  logic       full, empty, busy, start_transmit;
  logic [2:0] count;
  logic [7:0] data_tx;
  logic       end_transmit = 1'b0;
`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
  logic       overflow;
  logic       overflow_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reflet_uart_tx_fifo #(.depth_log2(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_data      (push_data),
    .flush          (flush),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .busy           (busy),
`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
`endif
    .data_tx        (data_tx),
    .start_transmit (start_transmit),
    .end_transmit   (end_transmit)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (full !== 1'b0)           begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (empty !== 1'b1)          begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (count !== 3'd0)          begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (data_tx !== 8'h00)       begin errors++; $display("FAIL reset_data got %h exp 00", data_tx); end
    checks++; if (start_transmit !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", start_transmit); end
`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
    checks++; if (overflow !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_single();
    push = 1'b1; push_data = 8'h55;
    tick();
    push = 1'b0;
    checks++; if (count !== 3'd1)          begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (start_transmit !== 1'b0) begin errors++; $display("FAIL single_nostart got %b exp 0", start_transmit); end
    tick();
    checks++; if (start_transmit !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", start_transmit); end
    checks++; if (data_tx !== 8'h55)       begin errors++; $display("FAIL single_data got %h exp 55", data_tx); end
    checks++; if (busy !== 1'b1)           begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    checks++; if (empty !== 1'b1)          begin errors++; $display("FAIL single_empty got %b exp 1", empty); end
    tick();
    checks++; if (start_transmit !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", start_transmit); end
    tick(); tick();
    checks++; if (busy !== 1'b1)           begin errors++; $display("FAIL single_busy_wait got %b exp 1", busy); end
    end_transmit = 1'b1;
    tick();
    end_transmit = 1'b0;
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
    tick();
    checks++; if (start_transmit !== 1'b0) begin errors++; $display("FAIL single_nomore got %b exp 0", start_transmit); end
  endtask

  // Push a leader byte and let it reach WAIT so subsequent pushes stay queued.
  task automatic go_busy(input logic [7:0] lead);
    push = 1'b1; push_data = lead;
    tick();
    push = 1'b0;
    tick(); tick();
  endtask

  task automatic push4(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = base + 8'(i);
      tick();
    end
    push = 1'b0;
  endtask

  task automatic test_fill_drain();
    go_busy(8'hF0);
    push4(8'h01);
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    for (int k = 1; k <= 4; k++) begin
      end_transmit = 1'b1;
      tick();
      end_transmit = 1'b0;
      tick();
      checks++; if (start_transmit !== 1'b1) begin errors++; $display("FAIL drain_start%0d got %b exp 1", k, start_transmit); end
      checks++; if (data_tx !== 8'(k))       begin errors++; $display("FAIL drain_data%0d got %h exp %h", k, data_tx, 8'(k)); end
      checks++; if (count !== 3'(4 - k))     begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", k, count, 4 - k); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    end_transmit = 1'b1;
    tick();
    end_transmit = 1'b0;
  endtask

  task automatic test_overflow();
    go_busy(8'hE0);
    push4(8'h11);
    push = 1'b1; push_data = 8'hAA;
    tick();
    push = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
`ifdef REFLET_UART_TX_FIFO_OVERFLOW_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
`endif
  endtask

  // One end pulse, optionally pushing in the same cycle as the following pop.
  task automatic cycle_byte(input logic do_push, input logic [7:0] pd,
                            input logic [7:0] exp_data, input logic [2:0] exp_count);
    end_transmit = 1'b1;
    tick();
    end_transmit = 1'b0;
    push = do_push; push_data = pd;
    tick();
    push = 1'b0;
    checks++; if (data_tx !== exp_data)   begin errors++; $display("FAIL pp_data got %h exp %h", data_tx, exp_data); end
    checks++; if (count !== exp_count)    begin errors++; $display("FAIL pp_count got %0d exp %0d", count, exp_count); end
    tick();
  endtask

  task automatic test_push_pop();
    cycle_byte(1'b0, 8'h00, 8'h11, 3'd3);
    cycle_byte(1'b0, 8'h00, 8'h12, 3'd2);
    cycle_byte(1'b1, 8'h21, 8'h13, 3'd2);
    cycle_byte(1'b1, 8'h22, 8'h14, 3'd2);
    cycle_byte(1'b0, 8'h00, 8'h21, 3'd1);
    cycle_byte(1'b0, 8'h00, 8'h22, 3'd0);
  endtask

  task automatic test_flush();
    push4(8'h31);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
    checks++; if (data_tx !== 8'h22) begin errors++; $display("FAIL flush_data got %h exp 22", data_tx); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL flush_busy got %b exp 1", busy); end
    end_transmit = 1'b1;
    tick();
    end_transmit = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b exp 0", busy); end
    tick(); tick();
    checks++; if (start_transmit !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_nostart got start=%b busy=%b exp 0 0", start_transmit, busy);
    end
    // Flush in the same cycle as an IDLE pop: head still goes out, queue ends empty.
    push = 1'b1; push_data = 8'h51;
    tick();
    push = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (start_transmit !== 1'b1 || data_tx !== 8'h51) begin
      errors++; $display("FAIL flushpop_tx got start=%b data=%h exp 1 51", start_transmit, data_tx);
    end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL flushpop_count got %0d empty=%b exp 0 1", count, empty);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    push = 1'b1; push_data = 8'h42;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    push = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL mid_busy0 got %b exp 0", busy); end
    checks++; if (data_tx !== 8'h00)       begin errors++; $display("FAIL mid_data got %h exp 00", data_tx); end
    checks++; if (empty !== 1'b1)          begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
    checks++; if (start_transmit !== 1'b0) begin errors++; $display("FAIL mid_start got %b exp 0", start_transmit); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_push_pop();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
